// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the NPC core sequencer: state encoding, the reset
// instruction and the alignment helper used on PC redirects.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_RESP   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } ctrl_state_e;

    // addi x0,x0,0 -- what the decoder sees before the first fetch lands
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // A redirect target is only legal on a 4-byte boundary
    function automatic logic is_misaligned(input logic [1:0] i_lsb);
        return (i_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/core_ctrl_fetch_watchdog.sv
// Bus watchdog for the fetch path: counts cycles spent waiting on the
// instruction bus and flags when the allowed budget is used up.
module core_ctrl_fetch_watchdog #(
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int unsigned CW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    // The count equals LIMIT during the last permitted cycle of the window
    localparam logic [CW-1:0] LIMIT = CW'(FETCH_TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Count waiting cycles; hold at the limit so a long wait never wraps to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CW'(1'b1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_timeout = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle sequencer for the NPC core: owns PC and instruction latch,
// fetches over a valid/ready bus, waits for execute, retires with a one-cycle
// register-file write enable and halts on ebreak or fault.
module core_ctrl #(
    parameter int unsigned                  DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0]        RESET_PC      = DATA_WIDTH'(32'h8000_0000),
    parameter int unsigned                  FETCH_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  if_req_valid,
    input  logic                  if_req_ready,
    output logic [DATA_WIDTH-1:0] if_req_addr,
    input  logic                  if_rsp_valid,
    output logic                  if_rsp_ready,
    input  logic [31:0]           if_rsp_data,
    output logic [31:0]           inst,
    output logic [DATA_WIDTH-1:0] pc,
    input  logic                  dec_regW,
    input  logic                  dec_ebreak,
    input  logic                  ex_done,
    input  logic                  ex_jump,
    input  logic [DATA_WIDTH-1:0] ex_target,
    output logic                  wb_en,
    output logic                  halted,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] inst_cnt
);

    import core_ctrl_pkg::*;

    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(32'd4);
    localparam logic [DATA_WIDTH-1:0] CNT_STEP = DATA_WIDTH'(1'b1);

    ctrl_state_e           r_state;
    ctrl_state_e           w_state_nxt;

    logic [DATA_WIDTH-1:0] r_pc;
    logic [31:0]           r_inst;
    logic [DATA_WIDTH-1:0] r_inst_cnt;

    // Execute results captured on ex_done so WB does not depend on live inputs
    logic                  r_regw;
    logic                  r_jump;
    logic [DATA_WIDTH-1:0] r_target;

    logic                  r_if_req_valid;
    logic                  r_if_rsp_ready;
    logic                  r_wb_en;
    logic                  r_halted;
    logic                  r_err;

    logic                  w_timeout;
    logic                  w_wd_en;
    logic                  w_wb_misaligned;
    logic                  w_exec_misaligned;
    logic                  w_wb_en_nxt;

    // The watchdog runs only while the bus owes us something
    assign w_wd_en = (r_state == ST_FETCH) || (r_state == ST_RESP);

    core_ctrl_fetch_watchdog #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) u_fetch_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_wd_en),
        .i_en      (w_wd_en),
        .o_timeout (w_timeout)
    );

    assign w_wb_misaligned   = r_jump && is_misaligned(r_target[1:0]);
    assign w_exec_misaligned = ex_jump && is_misaligned(ex_target[1:0]);

    // The write enable is decided as EXEC completes so it can be a plain flop in WB
    assign w_wb_en_nxt = (r_state == ST_EXEC) && ex_done && dec_regW && !w_exec_misaligned;

    // Next-state decode; handshakes are tested before the watchdog so they win a tie
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (if_req_ready) begin
                    w_state_nxt = ST_RESP;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_RESP: begin
                if (if_rsp_valid) begin
                    w_state_nxt = ST_DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_DECODE: begin
                if (dec_ebreak) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ex_done) begin
                    w_state_nxt = ST_WB;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_WB: begin
                if (w_wb_misaligned) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_ERR;
            end
        endcase
    end

    // State register and flopped control outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RESET;
            r_if_req_valid <= 1'b0;
            r_if_rsp_ready <= 1'b0;
            r_wb_en        <= 1'b0;
            r_halted       <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_if_req_valid <= (w_state_nxt == ST_FETCH);
            r_if_rsp_ready <= (w_state_nxt == ST_RESP);
            r_wb_en        <= w_wb_en_nxt;
            r_halted       <= (w_state_nxt == ST_HALT) || (w_state_nxt == ST_ERR);
            r_err          <= (w_state_nxt == ST_ERR);
        end
    end

    // Architectural state: PC, instruction latch, retire counter, execute capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inst     <= INST_NOP;
            r_inst_cnt <= {DATA_WIDTH{1'b0}};
            r_regw     <= 1'b0;
            r_jump     <= 1'b0;
            r_target   <= {DATA_WIDTH{1'b0}};
        end else begin
            if ((r_state == ST_RESP) && if_rsp_valid) begin
                r_inst <= if_rsp_data;
            end

            if ((r_state == ST_EXEC) && ex_done) begin
                r_regw   <= dec_regW;
                r_jump   <= ex_jump;
                r_target <= ex_target;
            end

            if ((r_state == ST_WB) && !w_wb_misaligned) begin
                r_pc       <= r_jump ? r_target : (r_pc + PC_STEP);
                r_inst_cnt <= r_inst_cnt + CNT_STEP;
            end else if ((r_state == ST_DECODE) && dec_ebreak) begin
                r_inst_cnt <= r_inst_cnt + CNT_STEP;
            end
        end
    end

    assign if_req_valid = r_if_req_valid;
    assign if_req_addr  = r_pc;
    assign if_rsp_ready = r_if_rsp_ready;
    assign inst         = r_inst;
    assign pc           = r_pc;
    assign wb_en        = r_wb_en;
    assign halted       = r_halted;
    assign err          = r_err;
    assign inst_cnt     = r_inst_cnt;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: directed scenarios feed expectation
// queues; a negedge monitor pops and compares on fetch handshakes and
// write-back pulses. A second instance with a short watchdog covers timeouts.
module tb_core_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy, vld, regw, ebreak, done, jump;
    logic [31:0] data, target;
    logic        req_valid, rsp_ready, wb_en, halted, err;
    logic [31:0] req_addr, inst, pc, inst_cnt;

    logic        t_rst, t_rdy, t_vld;
    logic        t_req_valid, t_rsp_ready, t_wb_en, t_halted, t_err;
    logic [31:0] t_req_addr, t_inst, t_pc, t_inst_cnt;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] cnt;
        int          lat;
    } ret_t;

    logic [31:0] addr_q[$];
    ret_t        ret_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    core_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h8000_0000), .FETCH_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(req_valid), .if_req_ready(rdy), .if_req_addr(req_addr),
        .if_rsp_valid(vld), .if_rsp_ready(rsp_ready), .if_rsp_data(data),
        .inst(inst), .pc(pc), .dec_regW(regw), .dec_ebreak(ebreak),
        .ex_done(done), .ex_jump(jump), .ex_target(target),
        .wb_en(wb_en), .halted(halted), .err(err), .inst_cnt(inst_cnt)
    );

    core_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h8000_0000), .FETCH_TIMEOUT(8)) dut_to (
        .clk(clk), .rst(t_rst),
        .if_req_valid(t_req_valid), .if_req_ready(t_rdy), .if_req_addr(t_req_addr),
        .if_rsp_valid(t_vld), .if_rsp_ready(t_rsp_ready), .if_rsp_data(32'h00A0_0093),
        .inst(t_inst), .pc(t_pc), .dec_regW(1'b0), .dec_ebreak(1'b0),
        .ex_done(1'b1), .ex_jump(1'b0), .ex_target(32'h0000_0000),
        .wb_en(t_wb_en), .halted(t_halted), .err(t_err), .inst_cnt(t_inst_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void push_ret(input logic [31:0] i, input logic [31:0] p,
                                     input logic [31:0] c, input int l);
        ret_t r;
        r.inst = i; r.pc = p; r.cnt = c; r.lat = l;
        ret_q.push_back(r);
    endfunction

    // Monitor state
    logic        prev_v, prev_hs, prev_rsp_hs, prev_rst;
    logic [31:0] prev_inst, prev_addr, mon_a;
    ret_t        mon_r;
    int          fetch_start = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_v      = 1'b0;
            prev_hs     = 1'b0;
            prev_rsp_hs = 1'b0;
            prev_rst    = 1'b1;
            prev_inst   = inst;
            prev_addr   = req_addr;
        end else begin
            if (req_valid && !prev_v) fetch_start = cyc;
            if (prev_v && !prev_hs && req_valid) check("addr_stable", req_addr, prev_addr);
            if (inst !== prev_inst) check("inst_only_on_handshake", {63'd0, (prev_rsp_hs || prev_rst)}, 64'd1);
            if (req_valid && rdy) begin
                if (addr_q.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL fetch_unexpected: got addr 0x%0h, want no request", req_addr);
                end else begin
                    mon_a = addr_q.pop_front();
                    check("fetch_addr", req_addr, mon_a);
                end
            end
            if (wb_en) begin
                if (ret_q.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL wb_unexpected: got wb_en=1 pc 0x%0h, want no write-back", pc);
                end else begin
                    mon_r = ret_q.pop_front();
                    check("wb_inst", inst, mon_r.inst);
                    check("wb_pc", pc, mon_r.pc);
                    check("wb_cnt", inst_cnt, mon_r.cnt);
                    check("wb_latency", cyc - fetch_start + 1, mon_r.lat);
                end
            end
            prev_v      = req_valid;
            prev_hs     = req_valid && rdy;
            prev_rsp_hs = rsp_ready && vld;
            prev_rst    = 1'b0;
            prev_inst   = inst;
            prev_addr   = req_addr;
        end
    end

    task automatic drained(input string name);
        check({name, "_addr_q_drained"}, addr_q.size(), 0);
        check({name, "_ret_q_drained"}, ret_q.size(), 0);
        addr_q.delete();
        ret_q.delete();
    endtask

    initial begin
        rst = 1'b1; t_rst = 1'b1;
        rdy = 1'b0; vld = 1'b0; regw = 1'b0; ebreak = 1'b0; done = 1'b0; jump = 1'b0;
        data = 32'h0; target = 32'h0;
        t_rdy = 1'b0; t_vld = 1'b1;

        // Reset state
        step(2);
        @(negedge clk);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_cnt", inst_cnt, 32'h0);
        check("rst_outputs", {req_valid, rsp_ready, wb_en, halted, err}, 5'b00000);

        // Back-to-back best case
        step(1);
        rdy = 1'b1; vld = 1'b1; done = 1'b1; regw = 1'b1; data = 32'h0050_0093;
        addr_q.push_back(32'h8000_0000);
        addr_q.push_back(32'h8000_0004);
        addr_q.push_back(32'h8000_0008);
        push_ret(32'h0050_0093, 32'h8000_0000, 32'd0, 5);
        push_ret(32'h0050_0093, 32'h8000_0004, 32'd1, 5);
        rst = 1'b0;
        step(11);
        @(negedge clk);
        check("bb_inst_cnt_after_10", inst_cnt, 32'd2);
        check("bb_pc", pc, 32'h8000_0008);
        step(1); rst = 1'b1; step(1);
        drained("bb");

        // Backpressure: ready low 3 cycles, valid low 4 cycles
        rdy = 1'b0; vld = 1'b0; done = 1'b1; regw = 1'b1; jump = 1'b0; data = 32'hDEAD_BEEF;
        addr_q.push_back(32'h8000_0000);
        push_ret(32'h0010_0113, 32'h8000_0000, 32'd0, 12);
        rst = 1'b0;
        step(4); rdy = 1'b1;
        step(1); rdy = 1'b0;
        step(3);
        @(negedge clk);
        check("bp_inst_held", inst, 32'h0000_0013);
        check("bp_rsp_ready", {31'd0, rsp_ready}, 32'd1);
        step(1); vld = 1'b1; data = 32'h0010_0113;
        step(1); vld = 1'b0; data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("bp_inst_latched", inst, 32'h0010_0113);
        step(3); rst = 1'b1; step(1);
        drained("bp");

        // Redirect, then misaligned redirect
        rdy = 1'b1; vld = 1'b1; done = 1'b1; regw = 1'b1; jump = 1'b1;
        target = 32'h8000_0100; data = 32'h0000_006F;
        addr_q.push_back(32'h8000_0000);
        addr_q.push_back(32'h8000_0100);
        push_ret(32'h0000_006F, 32'h8000_0000, 32'd0, 5);
        rst = 1'b0;
        step(6); target = 32'h8000_0102;
        step(5);
        @(negedge clk);
        check("mis_err", {halted, err}, 2'b11);
        check("mis_pc_kept", pc, 32'h8000_0100);
        check("mis_cnt_kept", inst_cnt, 32'd1);
        step(3);
        @(negedge clk);
        check("mis_absorbing", {req_valid, halted, err}, 3'b011);
        rst = 1'b1; jump = 1'b0; step(1);
        drained("mis");

        // ebreak
        rdy = 1'b1; vld = 1'b1; done = 1'b1; regw = 1'b0; ebreak = 1'b1; data = 32'h0010_0073;
        addr_q.push_back(32'h8000_0000);
        rst = 1'b0;
        step(4);
        @(negedge clk);
        check("ebk_halt", {halted, err}, 2'b10);
        check("ebk_cnt", inst_cnt, 32'd1);
        check("ebk_inst", inst, 32'h0010_0073);
        step(4);
        @(negedge clk);
        check("ebk_no_fetch", {req_valid, halted}, 2'b01);
        rst = 1'b1; ebreak = 1'b0; step(1);
        drained("ebk");

        // Mid-operation reset during RESP with valid high
        rdy = 1'b1; vld = 1'b1; done = 1'b1; regw = 1'b1; jump = 1'b1;
        target = 32'h8000_0040; data = 32'h0050_0093;
        addr_q.push_back(32'h8000_0000);
        addr_q.push_back(32'h8000_0040);
        push_ret(32'h0050_0093, 32'h8000_0000, 32'd0, 5);
        rst = 1'b0;
        step(6); vld = 1'b0;
        step(1); rst = 1'b1; vld = 1'b1; data = 32'h1234_5678;
        @(negedge clk);
        check("mid_pre_pc", pc, 32'h8000_0040);
        check("mid_pre_cnt", inst_cnt, 32'd1);
        step(1); rst = 1'b0; rdy = 1'b0; jump = 1'b0;
        @(negedge clk);
        check("mid_pc", pc, 32'h8000_0000);
        check("mid_inst", inst, 32'h0000_0013);
        check("mid_rsp_ready", {31'd0, rsp_ready}, 32'd0);
        check("mid_cnt", inst_cnt, 32'd0);
        step(3);
        @(negedge clk);
        check("mid_late_valid_ignored", inst, 32'h0000_0013);
        rst = 1'b1; vld = 1'b0; step(1);
        drained("mid");

        // Watchdog expiry with ready held low (FETCH_TIMEOUT = 8)
        t_rdy = 1'b0; t_vld = 1'b1; t_rst = 1'b0;
        step(8);
        @(negedge clk);
        check("to_before", {t_req_valid, t_err}, 2'b10);
        step(1);
        @(negedge clk);
        check("to_expired", {t_req_valid, t_halted, t_err}, 3'b011);
        t_rst = 1'b1; step(1);

        // Handshake in the last allowed cycle beats the watchdog
        t_rst = 1'b0;
        step(8); t_rdy = 1'b1;
        step(1); t_rdy = 1'b0;
        @(negedge clk);
        check("to_tie_resp", {t_rsp_ready, t_err}, 2'b10);
        step(1);
        @(negedge clk);
        check("to_tie_no_err", {t_halted, t_err}, 2'b00);
        check("to_tie_inst", t_inst, 32'h00A0_0093);
        t_rst = 1'b1; step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
